sv32_ptw: RTL and testbench
===========================

// Module: sv32_ptw
// PURPOSE
//  SV32 hardware page-table walker; the producer of TLB refills. On a TLB miss it reads the
//  two-level page table through a single-outstanding memory port. It checks the leaf PTE and
//  then either emits one tlb_update_t write to the TLB or a page-fault pulse.
//  Sits between the MMU miss logic, the TLB update port and the data-cache/bus read port.
// PARAMETERS
//  ASID_WIDTH   1   ASID width; must match the TLB it refills
// PORTS
//  clk_i            in   1          clock
//  rst_ni           in   1          reset, asynchronous, active-low
//  flush_i          in   1          abort walk (sfence.vma / satp write)
//  satp_ppn_i       in   22         root page-table PPN
//  walk_req_i       in   1          start walk (TLB miss); sampled only in IDLE
//  walk_vaddr_i     in   32         missing virtual address
//  walk_asid_i      in   ASID_WIDTH ASID of the miss
//  walk_is_store_i  in   1          miss caused by a store (D-bit check)
//  walk_busy_o      out  1          walker not in IDLE
//  walk_error_o     out  1          1-cycle page-fault pulse
//  walk_bad_vaddr_o out  32         faulting vaddr; valid with walk_error_o
//  update_o         out  tlb_update_t  TLB refill; .valid is a 1-cycle pulse
//  mem_req_o        out  1          PTE read request
//  mem_addr_o       out  34         PTE physical address
//  mem_gnt_i        in   1          request accepted
//  mem_rvalid_i     in   1          read data valid
//  mem_rdata_i      in   32         PTE read data (pte_t)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; captured vaddr/asid/store regs cleared.
//  FSM: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DRAIN.
//   IDLE   : walk_req_i & ~flush_i -> capture vaddr/asid/store -> L1_REQ (mem_req_o rises next cycle)
//   L1_REQ : mem_req_o=1, mem_addr_o={satp_ppn_i,vpn1,2'b00}; mem_gnt_i -> L1_WAIT
//   L1_WAIT: on mem_rvalid_i evaluate PTE (level 1):
//            ~v | (w&~r)                          -> fault
//            r|x (leaf): ppn[9:0]!=0 -> fault (misaligned); A/D check -> update is_4M=1 / fault
//            else (pointer) -> latch pte.ppn -> L0_REQ
//   L0_REQ : mem_addr_o={ppn_q,vpn0,2'b00}; mem_gnt_i -> L0_WAIT
//   L0_WAIT: on rvalid: ~v | (w&~r) | ~(r|x) -> fault; A/D check -> update is_4M=0 / fault
//   A/D check: ~a | (store_q & ~d) -> fault (no hardware A/D update)
//  Outcome of fault or update: registered; pulse is 1 cycle in the cycle after the rvalid; FSM returns to IDLE that same cycle.
//  update_o fields: vpn=vaddr_q[31:12], asid=asid_q, content=PTE, is_4M as above.
//  Memory handshake: mem_req_o and mem_addr_o are held stable until mem_gnt_i. Exactly one request is outstanding.
//  mem_rvalid_i arrives >=1 cycle after the grant. A grant in the same cycle as the request is legal.
//  flush_i (any state, highest priority):
//   IDLE/L*_REQ without a grant this cycle -> IDLE, mem_req_o drops, no update/error.
//   L*_WAIT, or L*_REQ with a grant this cycle -> DRAIN; DRAIN waits for rvalid, discards the data, -> IDLE.
//   flush_i in the rvalid cycle suppresses the update/error pulse.
//  walk_req_i while busy: ignored; the requester must hold or re-issue the request.
//  walk_busy_o=1 in every state except IDLE, including DRAIN.
//  Reset mid-walk: immediate IDLE. A late rvalid arriving in IDLE is ignored.
// CONFIGURATION
//  SV32_PTW_SUPERPAGE_EN defined: level-1 leaf accepted as 4 MiB page (is_4M=1).
//  Not defined: level-1 leaf -> page fault; update_o.is_4M tied 0.
// STRUCTURE
//  riscv_package: pte_t, tlb_update_t (shared with TLB), ptw_state_e enum, PTE_SIZE_LOG2=2 constant.
//  Sub-module sv32_pte_check: combinational PTE check (pte, level, is_store) -> {fault, leaf}.
//  Shared with the future iTLB-side walker arbiter.
// TESTING
//  4K walk: satp_ppn=0x10, vaddr=0x0040_3123, load; PTE1=0x0000_8001 @0x10004; PTE0=0x0003_00CF @0x2000C
//   -> 1 update pulse, vpn=0x00403, is_4M=0, content=0x000300CF; no error.
//  Superpage: PTE1=0x0000_00CF -> with macro: update is_4M=1 after one read; without: error pulse, bad_vaddr=vaddr.
//  Misaligned superpage: PTE1=0x0000_04CF -> error pulse, no update, only 1 memory read.
//  Bad PTEs: PTE0=0x0000_0005 (W&~R) -> error. PTE1=0x0 -> error. PTE0=0x0000_8001 (level-0 pointer) -> error.
//  Dirty: PTE0=0x0003_004F, store -> error; same PTE, load -> update.
//  Flush after L1 grant before rvalid -> busy until rvalid; no update/error; next walk_req gives correct update.
//  mem_gnt_i held low 5 cycles -> mem_addr_o stable throughout.

Source files
------------

// File: rtl/sv32_ptw_pkg.sv
// Shared SV32 walker types: PTE layout, TLB refill record, walker states and the PTE address helper.
package sv32_ptw_pkg;

    localparam int PTE_SIZE_LOG2  = 2;
    localparam int TLB_ASID_WIDTH = 1;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic                      valid;
        logic                      is_4M;
        logic [19:0]               vpn;
        logic [TLB_ASID_WIDTH-1:0] asid;
        pte_t                      content;
    } tlb_update_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DRAIN
    } ptw_state_e;

    // Physical address of the PTE selected by vpn inside the table at ppn.
    function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] vpn);
        return {ppn, vpn, {PTE_SIZE_LOG2{1'b0}}};
    endfunction

endpackage

// File: rtl/sv32_ptw_if.sv
// Single-outstanding PTE read port between the walker (master) and the cache/bus (slave).
interface sv32_ptw_if;
    logic        mem_req_o;
    logic [33:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/sv32_pte_check.sv
// Combinational SV32 PTE check: classifies a PTE as fault / leaf / pointer for a given level.
// Level-1 leaves are accepted only when SV32_PTW_SUPERPAGE_EN is defined.
module sv32_pte_check
    import sv32_ptw_pkg::*;
(
    input  pte_t pte_i,
    input  logic level_i,      // 1 = level-1 (root) PTE, 0 = level-0 PTE
    input  logic is_store_i,
    output logic fault_o,
    output logic leaf_o
);

    logic invalid;
    logic leaf;
    logic ad_fault;
    logic misaligned;
    logic superpage_ok;
    logic unused_bits;

    assign invalid    = ~pte_i.v | (pte_i.w & ~pte_i.r);
    assign leaf       = pte_i.r | pte_i.x;
    // No hardware A/D update: software must pre-set A (and D for stores).
    assign ad_fault   = ~pte_i.a | (is_store_i & ~pte_i.d);
    assign misaligned = level_i & (pte_i.ppn[9:0] != 10'd0);

`ifdef SV32_PTW_SUPERPAGE_EN
    assign superpage_ok = 1'b1;
`else
    assign superpage_ok = ~level_i;
`endif

    always_comb begin
        fault_o = 1'b0;
        if (invalid) begin
            fault_o = 1'b1;
        end else if (leaf) begin
            fault_o = misaligned | ad_fault | ~superpage_ok;
        end else begin
            fault_o = ~level_i;
        end
    end

    assign leaf_o      = ~invalid & leaf;
    assign unused_bits = ^{pte_i.rsw, pte_i.g, pte_i.u, pte_i.ppn[21:10]};

endmodule

// File: rtl/sv32_ptw.sv
// SV32 two-level hardware page-table walker producing TLB refills or page-fault pulses.
// Optional SV32_PTW_SUPERPAGE_EN accepts level-1 leaves as 4 MiB pages.
module sv32_ptw
    import sv32_ptw_pkg::*;
#(
    parameter int ASID_WIDTH = TLB_ASID_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [21:0]           satp_ppn_i,
    input  logic                  walk_req_i,
    input  logic [31:0]           walk_vaddr_i,
    input  logic [ASID_WIDTH-1:0] walk_asid_i,
    input  logic                  walk_is_store_i,
    output logic                  walk_busy_o,
    output logic                  walk_error_o,
    output logic [31:0]           walk_bad_vaddr_o,
    output tlb_update_t           update_o,
    sv32_ptw_if.master            mem
);

    ptw_state_e            state_q, state_d;
    logic [31:0]           vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    logic                  store_q, store_d;
    logic [21:0]           ppn_q, ppn_d;
    tlb_update_t           update_q, update_d;
    logic                  error_q, error_d;
    logic [31:0]           bad_vaddr_q, bad_vaddr_d;

    logic                  mem_req;
    logic [33:0]           mem_addr;
    pte_t                  pte;
    logic                  pte_fault;
    logic                  pte_leaf;
    logic                  at_level1;

    assign pte       = pte_t'(mem.mem_rdata_i);
    assign at_level1 = (state_q == L1_WAIT);

    sv32_pte_check u_check (
        .pte_i      (pte),
        .level_i    (at_level1),
        .is_store_i (store_q),
        .fault_o    (pte_fault),
        .leaf_o     (pte_leaf)
    );

    always_comb begin
        state_d     = state_q;
        vaddr_d     = vaddr_q;
        asid_d      = asid_q;
        store_d     = store_q;
        ppn_d       = ppn_q;
        update_d    = '0;
        error_d     = 1'b0;
        bad_vaddr_d = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;

        unique case (state_q)
            IDLE: begin
                if (walk_req_i && !flush_i) begin
                    vaddr_d = walk_vaddr_i;
                    asid_d  = walk_asid_i;
                    store_d = walk_is_store_i;
                    state_d = L1_REQ;
                end
            end
            L1_REQ, L0_REQ: begin
                mem_req  = 1'b1;
                mem_addr = (state_q == L1_REQ) ? pte_addr(satp_ppn_i, vaddr_q[31:22])
                                               : pte_addr(ppn_q, vaddr_q[21:12]);
                // A granted request must still have its response swallowed.
                if (flush_i) begin
                    state_d = mem.mem_gnt_i ? DRAIN : IDLE;
                end else if (mem.mem_gnt_i) begin
                    state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (mem.mem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else if (pte_fault) begin
                        error_d     = 1'b1;
                        bad_vaddr_d = vaddr_q;
                        state_d     = IDLE;
                    end else if (pte_leaf) begin
                        update_d.valid   = 1'b1;
`ifdef SV32_PTW_SUPERPAGE_EN
                        update_d.is_4M   = at_level1;
`else
                        update_d.is_4M   = 1'b0;
`endif
                        update_d.vpn     = vaddr_q[31:12];
                        update_d.asid    = asid_q;
                        update_d.content = pte;
                        state_d          = IDLE;
                    end else begin
                        ppn_d   = pte.ppn;
                        state_d = L0_REQ;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem.mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vaddr_q     <= '0;
            asid_q      <= '0;
            store_q     <= 1'b0;
            ppn_q       <= '0;
            update_q    <= '0;
            error_q     <= 1'b0;
            bad_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            vaddr_q     <= vaddr_d;
            asid_q      <= asid_d;
            store_q     <= store_d;
            ppn_q       <= ppn_d;
            update_q    <= update_d;
            error_q     <= error_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign mem.mem_req_o    = mem_req;
    assign mem.mem_addr_o   = mem_addr;
    assign walk_busy_o      = (state_q != IDLE);
    assign walk_error_o     = error_q;
    assign walk_bad_vaddr_o = bad_vaddr_q;
    assign update_o         = update_q;

endmodule

// File: tb/tb_sv32_ptw.sv
// Directed and randomized walks of sv32_ptw against a page-table reference model.
// Honours SV32_PTW_SUPERPAGE_EN the same way the design does.
module tb_sv32_ptw;
    import sv32_ptw_pkg::*;

`ifdef SV32_PTW_SUPERPAGE_EN
    localparam bit SUPER = 1'b1;
`else
    localparam bit SUPER = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic [21:0] satp_ppn_i = '0;
    logic        walk_req_i = 1'b0;
    logic [31:0] walk_vaddr_i = '0;
    logic [0:0]  walk_asid_i = '0;
    logic        walk_is_store_i = 1'b0;
    logic        walk_busy_o;
    logic        walk_error_o;
    logic [31:0] walk_bad_vaddr_o;
    tlb_update_t update_o;

    sv32_ptw_if mem_if ();

    always #5 clk_i = ~clk_i;

    sv32_ptw #(.ASID_WIDTH(1)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .satp_ppn_i       (satp_ppn_i),
        .walk_req_i       (walk_req_i),
        .walk_vaddr_i     (walk_vaddr_i),
        .walk_asid_i      (walk_asid_i),
        .walk_is_store_i  (walk_is_store_i),
        .walk_busy_o      (walk_busy_o),
        .walk_error_o     (walk_error_o),
        .walk_bad_vaddr_o (walk_bad_vaddr_o),
        .update_o         (update_o),
        .mem              (mem_if)
    );

    logic [31:0] pmem [logic [33:0]];
    int checks = 0;
    int failures = 0;

    // Memory timing knobs (set by the stimulus, read by the responder)
    int gnt_delay = 0;
    int rv_lat = 0;
    bit rand_timing = 1'b0;

    // Responder-owned state
    int          reads = 0;
    int          addr_changes = 0;
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    bit          rv_pending = 1'b0;
    bit          waiting = 1'b0;
    logic [31:0] rd_data = '0;
    logic [33:0] wait_addr = '0;

    // Monitor-owned state
    int          upd_cnt = 0;
    int          err_cnt = 0;
    tlb_update_t last_upd = '0;
    logic [31:0] last_bad = '0;
    logic        pulse_busy = 1'b0;

    function automatic logic [31:0] rd_mem(input logic [33:0] a);
        return pmem.exists(a) ? pmem[a] : 32'h0;
    endfunction

    always @(negedge clk_i) begin
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        if (!rst_ni) begin
            rv_pending = 1'b0;
            waiting    = 1'b0;
        end else if (rv_pending) begin
            if (rv_cnt == 0) begin
                mem_if.mem_rvalid_i = 1'b1;
                mem_if.mem_rdata_i  = rd_data;
                rv_pending          = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (mem_if.mem_req_o) begin
            if (!waiting) begin
                waiting   = 1'b1;
                wait_addr = mem_if.mem_addr_o;
                gnt_cnt   = rand_timing ? int'($urandom_range(0, 3)) : gnt_delay;
            end else if (mem_if.mem_addr_o !== wait_addr) begin
                addr_changes++;
            end
            if (gnt_cnt == 0) begin
                mem_if.mem_gnt_i = 1'b1;
                rd_data    = rd_mem(mem_if.mem_addr_o);
                rv_pending = 1'b1;
                rv_cnt     = rand_timing ? int'($urandom_range(0, 3)) : rv_lat;
                reads++;
                waiting    = 1'b0;
            end else begin
                gnt_cnt--;
            end
        end else begin
            waiting = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (update_o.valid) begin
                upd_cnt++;
                last_upd   = update_o;
                pulse_busy = walk_busy_o;
            end
            if (walk_error_o) begin
                err_cnt++;
                last_bad   = walk_bad_vaddr_o;
                pulse_busy = walk_busy_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference walk straight from the SV32 translation rules.
    function automatic void ref_walk(input logic [21:0] satp, input logic [31:0] va, input bit store,
                                     output bit fault, output bit is4m,
                                     output logic [31:0] pte, output int nreads);
        longint unsigned base;
        longint unsigned vpn;
        int lvl;
        bit done;
        bit v, r, w, x, a, d;
        base = satp; lvl = 1; done = 0;
        fault = 0; is4m = 0; nreads = 0; pte = 0;
        while (!done) begin
            vpn = (lvl == 1) ? longint'(va >> 22) : longint'((va >> 12) % 1024);
            pte = rd_mem(34'(base * 4096 + vpn * 4));
            nreads++;
            v = pte[0]; r = pte[1]; w = pte[2]; x = pte[3]; a = pte[6]; d = pte[7];
            if (!v || (w && !r)) begin
                fault = 1; done = 1;
            end else if (r || x) begin
                if (lvl == 1 && ((pte >> 10) % 1024) != 0) fault = 1;
                if (lvl == 1 && !SUPER) fault = 1;
                if (!a || (store && !d)) fault = 1;
                is4m = (lvl == 1) && !fault;
                done = 1;
            end else if (lvl == 0) begin
                fault = 1; done = 1;
            end else begin
                base = longint'(pte >> 10);
                lvl  = 0;
            end
        end
    endfunction

    task automatic do_walk(input string name, input logic [31:0] va, input logic asid, input bit store);
        bit f, is4m, done;
        logic [31:0] pte;
        int nr, u0, e0, r0;
        ref_walk(satp_ppn_i, va, store, f, is4m, pte, nr);
        u0 = upd_cnt; e0 = err_cnt; r0 = reads; done = 0;
        walk_vaddr_i = va; walk_asid_i = asid; walk_is_store_i = store;
        walk_req_i = 1'b1;
        tick();
        walk_req_i = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (upd_cnt != u0 || err_cnt != e0) done = 1;
        end
        chk({name, " timeout"}, 64'(!done), 64'd0);
        tick();
        tick();
        chk({name, " updates"}, 64'(upd_cnt - u0), f ? 64'd0 : 64'd1);
        chk({name, " errors"}, 64'(err_cnt - e0), f ? 64'd1 : 64'd0);
        chk({name, " reads"}, 64'(reads - r0), 64'(nr));
        chk({name, " busy_at_pulse"}, 64'(pulse_busy), 64'd0);
        if (f) begin
            chk({name, " bad_vaddr"}, 64'(last_bad), 64'(va));
        end else begin
            chk({name, " vpn"}, 64'(last_upd.vpn), 64'(va[31:12]));
            chk({name, " asid"}, 64'(last_upd.asid), 64'(asid));
            chk({name, " content"}, 64'(last_upd.content), 64'(pte));
            chk({name, " is_4M"}, 64'(last_upd.is_4M), 64'(is4m));
        end
        $display("walk %s va=%08h store=%0d fault=%0d reads=%0d", name, va, store, f, nr);
    endtask

    task automatic plant(input logic [21:0] satp, input logic [31:0] va,
                         input logic [31:0] pte1, input logic [31:0] pte0);
        pmem.delete();
        pmem[{satp, va[31:22], 2'b00}]       = pte1;
        pmem[{pte1[31:10], va[21:12], 2'b00}] = pte0;
    endtask

    initial begin
        int u0, e0, r0, c0;
        bit done, early;
        logic [31:0] va, p1, p0;

        // Reset state
        repeat (3) tick();
        chk("rst busy", 64'(walk_busy_o), 64'd0);
        chk("rst error", 64'(walk_error_o), 64'd0);
        chk("rst update", 64'(update_o), 64'd0);
        chk("rst mem_req", 64'(mem_if.mem_req_o), 64'd0);
        chk("rst bad_vaddr", 64'(walk_bad_vaddr_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        satp_ppn_i = 22'h10;
        plant(22'h10, 32'h0040_3123, 32'h0000_8001, 32'h0003_00CF);
        chk("4k l1 addr planted", 64'(rd_mem(34'h10004)), 64'h8001);
        do_walk("4k", 32'h0040_3123, 1'b1, 1'b0);
        chk("4k literal vpn", 64'(last_upd.vpn), 64'h00403);
        chk("4k literal content", 64'(last_upd.content), 64'h000300CF);

        plant(22'h10, 32'h0040_3123, 32'h0000_00CF, 32'h0);
        do_walk("superpage", 32'h0040_3123, 1'b0, 1'b0);
        plant(22'h10, 32'h0040_3123, 32'h0000_04CF, 32'h0);
        do_walk("misaligned", 32'h0040_3123, 1'b0, 1'b0);
        plant(22'h10, 32'h0040_3123, 32'h0000_8001, 32'h0000_0005);
        do_walk("w_not_r", 32'h0040_3123, 1'b0, 1'b0);
        plant(22'h10, 32'h0040_3123, 32'h0, 32'h0);
        do_walk("pte1_zero", 32'h0040_3123, 1'b0, 1'b0);
        plant(22'h10, 32'h0040_3123, 32'h0000_8001, 32'h0000_8001);
        do_walk("l0_pointer", 32'h0040_3123, 1'b0, 1'b0);
        plant(22'h10, 32'h0040_3123, 32'h0000_8001, 32'h0003_004F);
        do_walk("dirty_store", 32'h0040_3123, 1'b0, 1'b1);
        do_walk("dirty_load", 32'h0040_3123, 1'b0, 1'b0);

        // Flush after the level-1 grant: drain the response, emit nothing
        plant(22'h10, 32'h0040_3123, 32'h0000_8001, 32'h0003_00CF);
        rv_lat = 6;
        u0 = upd_cnt; e0 = err_cnt; r0 = reads; done = 0;
        walk_vaddr_i = 32'h0040_3123; walk_is_store_i = 1'b0;
        walk_req_i = 1'b1;
        tick();
        walk_req_i = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (reads != r0) done = 1;
        end
        chk("flush grant timeout", 64'(!done), 64'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush busy in drain", 64'(walk_busy_o), 64'd1);
        done = 0; early = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!walk_busy_o) begin
                done  = 1;
                early = rv_pending;
            end else begin
                tick();
            end
        end
        chk("flush drain timeout", 64'(!done), 64'd0);
        chk("flush idle before rvalid", 64'(early), 64'd0);
        tick();
        tick();
        chk("flush no update", 64'(upd_cnt - u0), 64'd0);
        chk("flush no error", 64'(err_cnt - e0), 64'd0);
        rv_lat = 0;
        do_walk("after_flush", 32'h0040_3123, 1'b0, 1'b0);

        // Flush while the level-1 request waits for a grant
        gnt_delay = 3;
        u0 = upd_cnt; e0 = err_cnt; r0 = reads;
        walk_req_i = 1'b1;
        tick();
        walk_req_i = 1'b0;
        chk("req_flush mem_req up", 64'(mem_if.mem_req_o), 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("req_flush busy", 64'(walk_busy_o), 64'd0);
        chk("req_flush mem_req", 64'(mem_if.mem_req_o), 64'd0);
        repeat (6) tick();
        chk("req_flush reads", 64'(reads - r0), 64'd0);
        chk("req_flush pulses", 64'((upd_cnt - u0) + (err_cnt - e0)), 64'd0);

        // Grant withheld for 5 cycles: address must not move
        gnt_delay = 5;
        c0 = addr_changes;
        do_walk("slow_gnt", 32'h0040_3123, 1'b1, 1'b0);
        chk("slow_gnt addr stable", 64'(addr_changes - c0), 64'd0);
        gnt_delay = 0;

        // Randomized tables, addresses and memory timing
        rand_timing = 1'b1;
        for (int n = 0; n < 40; n++) begin
            satp_ppn_i = 22'($urandom_range(16, 31));
            va = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    p1 = {10'd0, 12'($urandom_range(256, 511)), 2'b00, 8'h01};
                2:       p1 = {12'($urandom_range(1, 3)), 10'd0, 2'b00, 8'($urandom) | 8'h01};
                default: p1 = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       p0 = {$urandom_range(0, 4194303), 2'b00, 8'hCF};
                1:       p0 = {$urandom_range(0, 4194303), 2'b00, 8'h4F};
                2:       p0 = {$urandom_range(0, 4194303), 2'b00, 8'($urandom) | 8'h41};
                default: p0 = $urandom;
            endcase
            plant(satp_ppn_i, va, p1, p0);
            do_walk($sformatf("rand%0d", n), va, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
